// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 adder front end.
`timescale 1ns/1ps
package fp16_pkg;

  localparam int unsigned EXP_W     = 5;
  localparam int unsigned MAN_W     = 10;
  localparam int unsigned GRS_W     = 3;
  localparam int unsigned SIG_W     = MAN_W + 1;
  localparam int unsigned ALIGN_W   = SIG_W + GRS_W;
  // Shifting further than this only moves zeros into an already-set sticky bit.
  localparam int unsigned ALIGN_MAX = MAN_W + 1 + GRS_W;

  typedef enum logic [2:0] {IDLE, CMP, SWAP, SHIFT, DONE} align_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp16_t;

  // Subnormals share the exponent of the smallest normal.
  function automatic logic [EXP_W-1:0] eff_exp(input fp16_t x);
    return (x.exp == '0) ? EXP_W'(1) : x.exp;
  endfunction

  // Significand with the hidden bit made explicit.
  function automatic logic [SIG_W-1:0] full_sig(input fp16_t x);
    return {(x.exp != '0), x.frac};
  endfunction

endpackage

// File: rtl/fp16_sticky_shreg.sv
// Loadable right shifter; the LSB accumulates everything shifted past it.
`timescale 1ns/1ps
module fp16_sticky_shreg
  import fp16_pkg::*;
#(
  parameter int unsigned Width = ALIGN_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             shift_i,
  output logic [Width-1:0] val_o
);

  logic [Width-1:0] val_d, val_q;

  // Load has priority; a shift ORs the old round and sticky bits into the new sticky bit.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (shift_i) begin
      val_d = {1'b0, val_q[Width-1:2], val_q[1] | val_q[0]};
    end
  end

  // Shift register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/fp16_align_ctrl.sv
// Exponent compare and significand alignment sequencer using a shared external subtractor.
`timescale 1ns/1ps
module fp16_align_ctrl
  import fp16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        a,
  input  logic [15:0]        b,
  output logic [EXP_W-1:0]   sub_a,
  output logic [EXP_W-1:0]   sub_b,
  input  logic [EXP_W-1:0]   sub_s,
  input  logic               sub_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   exp_big,
  output logic [SIG_W-1:0]   man_big,
  output logic [ALIGN_W-1:0] man_small,
  output logic               sign_big,
  output logic               sign_small,
  output logic               swapped
);

  align_state_t     state_d, state_q;
  logic [EXP_W-1:0] eff_a_d, eff_a_q, eff_b_d, eff_b_q;
  logic [SIG_W-1:0] man_a_d, man_a_q, man_b_d, man_b_q;
  logic             sign_a_d, sign_a_q, sign_b_d, sign_b_q;
  logic [EXP_W-1:0] diff_d, diff_q, cnt_d, cnt_q, cnt_inc;
  logic [EXP_W-1:0] exp_big_d, exp_big_q;
  logic [SIG_W-1:0] man_big_d, man_big_q;
  logic             sign_big_d, sign_big_q, sign_small_d, sign_small_q;
  logic             swapped_d, swapped_q;
  logic             sh_load, sh_shift;
  logic [ALIGN_W-1:0] sh_load_val;
  fp16_t            a_f, b_f;

  assign a_f     = a;
  assign b_f     = b;
  assign cnt_inc = cnt_q + EXP_W'(1);

  // Next-state, subtractor operand steering and capture of the compare result.
  always_comb begin
    state_d      = state_q;
    eff_a_d      = eff_a_q;
    eff_b_d      = eff_b_q;
    man_a_d      = man_a_q;
    man_b_d      = man_b_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    exp_big_d    = exp_big_q;
    man_big_d    = man_big_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    swapped_d    = swapped_q;
    sub_a        = '0;
    sub_b        = '0;
    sh_load      = 1'b0;
    sh_shift     = 1'b0;
    sh_load_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          eff_a_d  = eff_exp(a_f);
          eff_b_d  = eff_exp(b_f);
          man_a_d  = full_sig(a_f);
          man_b_d  = full_sig(b_f);
          sign_a_d = a_f.sign;
          sign_b_d = b_f.sign;
          state_d  = CMP;
        end
      end
      CMP: begin
        sub_a = eff_a_q;
        sub_b = eff_b_q;
        if (sub_cout) begin
          exp_big_d    = eff_a_q;
          man_big_d    = man_a_q;
          sign_big_d   = sign_a_q;
          sign_small_d = sign_b_q;
          swapped_d    = 1'b0;
          diff_d       = sub_s;
          cnt_d        = '0;
          sh_load      = 1'b1;
          sh_load_val  = {man_b_q, {GRS_W{1'b0}}};
          state_d      = (sub_s == '0) ? DONE : SHIFT;
        end else begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        // B is strictly larger here, so the difference is never zero.
        sub_a        = eff_b_q;
        sub_b        = eff_a_q;
        exp_big_d    = eff_b_q;
        man_big_d    = man_b_q;
        sign_big_d   = sign_b_q;
        sign_small_d = sign_a_q;
        swapped_d    = 1'b1;
        diff_d       = sub_s;
        cnt_d        = '0;
        sh_load      = 1'b1;
        sh_load_val  = {man_a_q, {GRS_W{1'b0}}};
        state_d      = SHIFT;
      end
      SHIFT: begin
        sh_shift = 1'b1;
        cnt_d    = cnt_inc;
        if (cnt_inc == diff_q || cnt_inc == EXP_W'(ALIGN_MAX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      eff_a_q      <= '0;
      eff_b_q      <= '0;
      man_a_q      <= '0;
      man_b_q      <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      diff_q       <= '0;
      cnt_q        <= '0;
      exp_big_q    <= '0;
      man_big_q    <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      swapped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      eff_a_q      <= eff_a_d;
      eff_b_q      <= eff_b_d;
      man_a_q      <= man_a_d;
      man_b_q      <= man_b_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      exp_big_q    <= exp_big_d;
      man_big_q    <= man_big_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      swapped_q    <= swapped_d;
    end
  end

  fp16_sticky_shreg #(
    .Width (ALIGN_W)
  ) u_shreg (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (sh_load),
    .load_val_i (sh_load_val),
    .shift_i    (sh_shift),
    .val_o      (man_small)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign exp_big    = exp_big_q;
  assign man_big    = man_big_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign swapped    = swapped_q;

endmodule

// File: tb/tb_fp16_align_ctrl.sv
// Directed bench for the FP16 alignment sequencer with a behavioural exponent subtractor.
`timescale 1ns/1ps
module tb_fp16_align_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, sub_cout, sign_big, sign_small, swapped;
  logic [4:0]  sub_a, sub_b, sub_s, exp_big;
  logic [10:0] man_big;
  logic [13:0] man_small;
  logic [5:0]  sub_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Two's-complement subtract: carry out is set exactly when sub_a >= sub_b.
  assign sub_sum  = {1'b0, sub_a} + {1'b0, ~sub_b} + 6'd1;
  assign sub_s    = sub_sum[4:0];
  assign sub_cout = sub_sum[5];

  fp16_align_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_s      (sub_s),
    .sub_cout   (sub_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .exp_big    (exp_big),
    .man_big    (man_big),
    .man_small  (man_small),
    .sign_big   (sign_big),
    .sign_small (sign_small),
    .swapped    (swapped)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_result(input string tag, input logic [4:0] e_exp, input logic [10:0] e_mb,
                              input logic [13:0] e_ms, input logic e_sw, input logic e_sb,
                              input logic e_ss);
    check_eq({tag, ".exp_big"}, 32'(exp_big), 32'(e_exp));
    check_eq({tag, ".man_big"}, 32'(man_big), 32'(e_mb));
    check_eq({tag, ".man_small"}, 32'(man_small), 32'(e_ms));
    check_eq({tag, ".swapped"}, 32'(swapped), 32'(e_sw));
    check_eq({tag, ".sign_big"}, 32'(sign_big), 32'(e_sb));
    check_eq({tag, ".sign_small"}, 32'(sign_small), 32'(e_ss));
  endtask

  // Issue one operand pair, count cycles from the capture edge to out_valid, check outputs.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input int e_lat, input logic [4:0] e_exp, input logic [10:0] e_mb,
                        input logic [13:0] e_ms, input logic e_sw, input logic e_sb,
                        input logic e_ss, input bit chk_sub);
    int c;
    @(negedge clk);
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (chk_sub) begin
      check_eq({tag, ".cmp_sub_a"}, 32'(sub_a), 32'd14);
      check_eq({tag, ".cmp_sub_b"}, 32'(sub_b), 32'd15);
    end
    c = 0;
    do begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (chk_sub && c == 1) begin
        check_eq({tag, ".swap_sub_a"}, 32'(sub_a), 32'd15);
        check_eq({tag, ".swap_sub_b"}, 32'(sub_b), 32'd14);
      end
    end while (!out_valid && c < 40);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".latency"}, 32'(c), 32'(e_lat));
    check_result(tag, e_exp, e_mb, e_ms, e_sw, e_sb, e_ss);
  endtask

  task automatic release_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, ".rel_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, ".rel_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit seen;
    // Reset state
    #2;
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.sub_a", 32'(sub_a), 32'd0);
    check_eq("rst.sub_b", 32'(sub_b), 32'd0);
    check_result("rst", 5'd0, 11'd0, 14'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 vs 0.5: one shift
    run_op("t1", 16'h3C00, 16'h3800, 2, 5'd15, 11'h400, 14'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t1");
    // 0.5 vs 1.0: swap path, subtractor operands reversed in SWAP
    run_op("t2", 16'h3800, 16'h3C00, 3, 5'd15, 11'h400, 14'h1000, 1'b1, 1'b0, 1'b0, 1'b1);
    release_op("t2");
    // Equal exponents
    run_op("t3", 16'h3C00, 16'h3C00, 1, 5'd15, 11'h400, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t3");
    // Exponent 30 vs subnormal: diff 29 capped at 14 shifts, only sticky survives
    run_op("t4", 16'h7800, 16'h0001, 15, 5'd30, 11'h400, 14'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t4");
    // Signs: -1.0 vs 0.75
    run_op("t5", 16'hBC00, 16'h3A00, 2, 5'd15, 11'h400, 14'h1800, 1'b0, 1'b1, 1'b0, 1'b0);
    release_op("t5");
    // 8.0 vs 1.0009765625: three shifts, LSB folds into sticky
    run_op("t6", 16'h4800, 16'h3C01, 4, 5'd18, 11'h400, 14'h0401, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t6");
    // Both zero: no hidden bits, effective exponents equal
    run_op("t7", 16'h0000, 16'h0000, 1, 5'd1, 11'h000, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t7");

    // Hold in DONE with out_ready low; a new in_valid must be ignored
    run_op("t8", 16'h3800, 16'h3C00, 3, 5'd15, 11'h400, 14'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
    a = 16'h4800;
    b = 16'h0001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("hold.out_valid", 32'(out_valid), 32'd1);
      check_eq("hold.in_ready", 32'(in_ready), 32'd0);
      check_result("hold", 5'd15, 11'h400, 14'h1000, 1'b1, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    release_op("t8");
    run_op("t9", 16'h4800, 16'h3C01, 4, 5'd18, 11'h400, 14'h0401, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t9");

    // Reset in the middle of SHIFT aborts the operation
    @(negedge clk);
    a = 16'h7800;
    b = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mrst.in_ready", 32'(in_ready), 32'd1);
    check_eq("mrst.out_valid", 32'(out_valid), 32'd0);
    check_eq("mrst.man_small", 32'(man_small), 32'd0);
    check_eq("mrst.exp_big", 32'(exp_big), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("mrst.no_stale", 32'(seen), 32'd0);
    run_op("t10", 16'h3C00, 16'h3800, 2, 5'd15, 11'h400, 14'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_op("t10");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
